// File: rtl/riscq_ureg_dispatch.sv
// riscq_ureg_dispatch
// -------------------
// Buffers user-register writes from the riscq core in a show-ahead FIFO and
// dispatches them to N_CH downstream channels over a valid/ready handshake.
// A write whose address MSB is set is a barrier. It pushes nothing. Instead
// it halts the core until the FIFO has drained and every channel named in the
// barrier mask has signalled continue. A timeout escape releases the core and
// raises a sticky error.
//
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_ureg_waddr    core ureg write address (MSB = barrier flag)
//   i_ureg_wdata    core ureg write data (barrier: low N_CH bits = mask)
//   i_ureg_we       core ureg write enable
//   o_hlt           halt request to core (FIFO full or barrier in progress)
//   o_waddr         dispatched register address, addr[ADDR_W-2-CH_W:0]
//   o_wdata         dispatched data
//   o_wch           target channel, addr[ADDR_W-2 -: CH_W]
//   o_wvalid        FIFO head valid
//   i_wready        downstream accept
//   i_continue      per-channel continue pulses
//   o_level         FIFO occupancy
//   o_timeout       sticky barrier-timeout error
//
// Parameter constraints: DEPTH must be a power of 2 and >= 2. N_CH must be
// >= 2 and <= DATA_W. TO_W must be >= 2.

module riscq_ureg_dispatch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int N_CH   = 4,
  parameter int TO_W   = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [ADDR_W-1:0]                  i_ureg_waddr,
  input  logic [DATA_W-1:0]                  i_ureg_wdata,
  input  logic                               i_ureg_we,
  output logic                               o_hlt,
  output logic [ADDR_W-2-$clog2(N_CH):0]     o_waddr,
  output logic [DATA_W-1:0]                  o_wdata,
  output logic [$clog2(N_CH)-1:0]            o_wch,
  output logic                               o_wvalid,
  input  logic                               i_wready,
  input  logic [N_CH-1:0]                    i_continue,
  output logic [$clog2(DEPTH):0]             o_level,
  output logic                               o_timeout
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int EA_W  = ADDR_W - 1;
  localparam int E_W   = EA_W + DATA_W;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  // The counter value during the WAIT cycle whose increment would reach the
  // all-ones terminal count; the timeout fires in that cycle.
  localparam logic [TO_W-1:0]  TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WAIT
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [E_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [E_W-1:0]     head;
  logic [EA_W-1:0]    head_addr;

  logic               full;
  logic               empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               barrier_acc;

  logic [N_CH-1:0]    mask;
  logic [N_CH-1:0]    cont;
  logic [N_CH-1:0]    cont_seen;
  logic [N_CH-1:0]    cont_clr;
  logic               covered;

  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_cnt_nxt;
  logic               set_timeout;

  // Full and empty come from the occupancy count rather than from the
  // pointers, so a wrapped write pointer is never ambiguous.
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  // Halt depends only on registered state, so it never forms a
  // combinational loop with the core's write enable.
  assign o_hlt = full | (state != ST_IDLE);

  assign accept      = i_ureg_we & ~o_hlt;
  assign push        = accept & ~i_ureg_waddr[ADDR_W-1];
  assign barrier_acc = accept &  i_ureg_waddr[ADDR_W-1];
  assign pop         = ~empty & i_wready;

  // The head entry is read straight from the storage array. Its slot is not
  // rewritten while it is pending, so the outputs hold steady under
  // backpressure.
  assign head      = mem[rd_ptr];
  assign head_addr = head[E_W-1:DATA_W];
  assign o_wdata   = head[DATA_W-1:0];
  assign o_waddr   = head_addr[EA_W-1-CH_W:0];
  assign o_wch     = head_addr[EA_W-1 -: CH_W];
  assign o_wvalid  = ~empty;
  assign o_level   = level;

  // A continue pulse in the current cycle counts toward releasing the barrier.
  assign cont_seen = cont | i_continue;
  assign covered   = ((cont_seen & mask) == mask);

  // Storage array. This block has no reset: contents are only observable
  // when the level says the slot holds data.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_ureg_waddr[EA_W-1:0], i_ureg_wdata};
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
  // the level unchanged. Reset discards any queued entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Barrier sequencing and timeout counter.
  // DRAIN waits for the registered level to reach zero, so the final pop has
  // completed before WAIT starts.
  // WAIT leaves as soon as the mask is covered. An empty mask is covered
  // immediately, so it exits on the first WAIT cycle.
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    cont_clr    = '0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (barrier_acc) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          state_nxt  = ST_WAIT;
          to_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (covered) begin
          state_nxt = ST_IDLE;
          cont_clr  = mask;
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          cont_clr    = mask;
          set_timeout = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, barrier mask latch and the sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      mask      <= '0;
      o_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (barrier_acc) begin
        mask <= i_ureg_wdata[N_CH-1:0];
      end
      if (set_timeout) begin
        o_timeout <= 1'b1;
      end
    end
  end

  // Continue flags are sticky and are set in any state. A clear on WAIT exit
  // is applied before the set, so a pulse in the clearing cycle survives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cont <= '0;
    end else begin
      cont <= (cont & ~cont_clr) | i_continue;
    end
  end

endmodule
